// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared state encoding and constants for the RSA host sequencer
package rsa_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_RD_REQ,
      S_RD_CAP,
      S_SEND
   } seq_state_t;

   localparam logic [1:0] RSEL_RES = 2'd0;
   localparam logic [1:0] RSEL_M   = 2'd1;
   localparam logic [1:0] RSEL_E   = 2'd2;
   localparam logic [1:0] RSEL_N   = 2'd3;

   localparam int DEF_KEY_BYTES = 32;
   localparam int DEF_WAIT_MAX  = 2000000;

endpackage

// File: rtl/rsa_host_seq.sv
// rtl/rsa_host_seq.sv - loads N/E/M from a host byte stream into the RSA core,
// runs it and streams the result back out
module rsa_host_seq
   import rsa_pkg::*;
#(
   parameter int KEY_BYTES = DEF_KEY_BYTES,
   parameter int WAIT_MAX  = DEF_WAIT_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       core_we_n,
   output logic       core_oe_n,
   output logic       core_start,
   output logic [1:0] core_reg_sel,
   output logic [5:0] core_addr,
   output logic [7:0] core_wdata,
   input  logic [7:0] core_rdata,
   input  logic       core_busy,
   output logic       err_timeout,
   output logic       seq_busy
);

   localparam int CNT_W  = $clog2(3 * KEY_BYTES + 1);
   localparam int WAIT_W = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_TOTAL = CNT_W'(3 * KEY_BYTES);
   localparam logic [CNT_W-1:0]  RES_LAST  = CNT_W'(KEY_BYTES - 1);
   localparam logic [5:0]        ADDR_LAST = 6'(KEY_BYTES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   seq_state_t        state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [WAIT_W-1:0] wait_cnt, wait_nx;
   logic              busy_seen, busy_seen_nx;
   logic              in_ready_nx, out_valid_nx, we_nx, oe_nx, start_nx;
   logic              err_nx, seq_busy_nx;
   logic [7:0]        out_data_nx, wdata_nx;
   logic [1:0]        sel_nx;
   logic [5:0]        addr_nx;
   logic              accept;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         wait_cnt     <= '0;
         busy_seen    <= 1'b0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= 8'h00;
         core_we_n    <= 1'b1;
         core_oe_n    <= 1'b1;
         core_start   <= 1'b0;
         core_reg_sel <= RSEL_RES;
         core_addr    <= 6'd0;
         core_wdata   <= 8'h00;
         err_timeout  <= 1'b0;
         seq_busy     <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         wait_cnt     <= wait_nx;
         busy_seen    <= busy_seen_nx;
         in_ready     <= in_ready_nx;
         out_valid    <= out_valid_nx;
         out_data     <= out_data_nx;
         core_we_n    <= we_nx;
         core_oe_n    <= oe_nx;
         core_start   <= start_nx;
         core_reg_sel <= sel_nx;
         core_addr    <= addr_nx;
         core_wdata   <= wdata_nx;
         err_timeout  <= err_nx;
         seq_busy     <= seq_busy_nx;
      end
   end

   // Every output is computed one cycle ahead here and registered above.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      wait_nx      = wait_cnt;
      busy_seen_nx = busy_seen;
      in_ready_nx  = 1'b0;
      out_valid_nx = out_valid;
      out_data_nx  = out_data;
      we_nx        = 1'b1;
      oe_nx        = 1'b1;
      start_nx     = 1'b0;
      sel_nx       = core_reg_sel;
      addr_nx      = core_addr;
      wdata_nx     = core_wdata;
      err_nx       = err_timeout;

      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = S_LOAD;
               cnt_nx   = CNT_W'(1);
               we_nx    = 1'b0;
               wdata_nx = in_data;
               sel_nx   = RSEL_N;
               addr_nx  = 6'd0;
               err_nx   = 1'b0;
            end else begin
               in_ready_nx = 1'b1;
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_nx    = 1'b0;
               wdata_nx = in_data;
               cnt_nx   = cnt + 1'b1;
               // Operand boundary: wrap the byte index and step N -> E -> M.
               if (core_addr == ADDR_LAST) begin
                  addr_nx = 6'd0;
                  sel_nx  = core_reg_sel - 2'd1;
               end else begin
                  addr_nx = core_addr + 6'd1;
               end
            end else if (cnt == CNT_TOTAL) begin
               state_nx     = S_START;
               start_nx     = 1'b1;
               busy_seen_nx = 1'b0;
               wait_nx      = '0;
            end else begin
               in_ready_nx = 1'b1;
            end
         end
         S_START: begin
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            busy_seen_nx = busy_seen | core_busy;
            if (busy_seen && !core_busy) begin
               state_nx = S_RD_REQ;
               cnt_nx   = '0;
               sel_nx   = RSEL_RES;
               addr_nx  = 6'd0;
               oe_nx    = 1'b0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nx    = S_IDLE;
               err_nx      = 1'b1;
               in_ready_nx = 1'b1;
            end else begin
               wait_nx = wait_cnt + 1'b1;
            end
         end
         S_RD_REQ: begin
            state_nx = S_RD_CAP;
         end
         S_RD_CAP: begin
            out_data_nx  = core_rdata;
            out_valid_nx = 1'b1;
            state_nx     = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               out_valid_nx = 1'b0;
               cnt_nx       = cnt + 1'b1;
               if (cnt == RES_LAST) begin
                  state_nx    = S_IDLE;
                  in_ready_nx = 1'b1;
               end else begin
                  state_nx = S_RD_REQ;
                  oe_nx    = 1'b0;
                  addr_nx  = core_addr + 6'd1;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      seq_busy_nx = (state_nx != S_IDLE);
   end

endmodule
